// File: rtl/dma_copy_engine.sv
// Memory-to-memory byte-copy engine: programmed through an MMIO slot, copies
// LEN bytes SRC->DST in ascending order as a system-bus initiator.
module dma_copy_engine #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rs,
  input  logic        we,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bm_addr,
  output logic        bm_we,
  output logic [7:0]  bm_wdata,
  input  logic [7:0]  bm_rdata,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] src_r, src_s, dst_r, dst_s, len_r, len_s;
  logic [15:0] bm_addr_r, bm_addr_s;
  logic [7:0]  data_r, data_s, wait_r, wait_s;
  logic [7:0]  dout_r, dout_s, rd_mux_s, bm_wdata_r, bm_wdata_s;
  logic        ie_r, ie_s, done_r, done_s, aborted_r, aborted_s;
  logic        abort_pend_r, abort_pend_s;
  logic        bus_req_r, bus_req_s, bm_we_r, bm_we_s, irq_r, irq_s;
  logic        slot_wr_s, slot_rd_s, ctrl_wr_s, busy_s;
  logic        start_s, abort_req_s, abort_s, rd_done_s;

  assign slot_wr_s   = en & we;
  assign slot_rd_s   = en & ~we;
  assign ctrl_wr_s   = slot_wr_s & (rs == 3'd6);
  assign busy_s      = (state_r != S_IDLE);
  assign start_s     = ctrl_wr_s & din[0] & ~busy_s;
  assign abort_req_s = ctrl_wr_s & din[1] & busy_s;
  // An abort written on the same edge as a boundary is honoured immediately.
  assign abort_s     = abort_pend_r | abort_req_s;
  assign rd_done_s   = (int'(wait_r) >= (RD_LAT - 1));

  // Slot read-back mux (live address/length values).
  always_comb begin
    rd_mux_s = 8'd0;
    case (rs)
      3'd0:    rd_mux_s = src_r[7:0];
      3'd1:    rd_mux_s = src_r[15:8];
      3'd2:    rd_mux_s = dst_r[7:0];
      3'd3:    rd_mux_s = dst_r[15:8];
      3'd4:    rd_mux_s = len_r[7:0];
      3'd5:    rd_mux_s = len_r[15:8];
      3'd6:    rd_mux_s = {5'd0, ie_r, 2'd0};
      3'd7:    rd_mux_s = {5'd0, aborted_r, done_r, busy_s};
      default: rd_mux_s = 8'd0;
    endcase
  end

  // Next-state, register-file and bus-output computation.
  always_comb begin
    state_s      = state_r;
    src_s        = src_r;
    dst_s        = dst_r;
    len_s        = len_r;
    data_s       = data_r;
    wait_s       = wait_r;
    aborted_s    = aborted_r;
    abort_pend_s = abort_pend_r | abort_req_s;
    if (ctrl_wr_s) ie_s = din[2];
    else           ie_s = ie_r;
    if (slot_rd_s && (rs == 3'd7)) done_s = 1'b0;
    else                           done_s = done_r;
    if (slot_rd_s) dout_s = rd_mux_s;
    else           dout_s = dout_r;

    if (slot_wr_s && !busy_s) begin
      case (rs)
        3'd0:    src_s[7:0]  = din;
        3'd1:    src_s[15:8] = din;
        3'd2:    dst_s[7:0]  = din;
        3'd3:    dst_s[15:8] = din;
        3'd4:    len_s[7:0]  = din;
        3'd5:    len_s[15:8] = din;
        default: src_s = src_r;
      endcase
    end else begin
      src_s = src_r;
    end

    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          done_s       = 1'b0;
          aborted_s    = 1'b0;
          abort_pend_s = 1'b0;
          if (len_r == 16'd0) state_s = S_FIN;
          else                state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (abort_s) begin
          aborted_s = 1'b1;
          state_s   = S_FIN;
        end else if (bus_gnt) begin
          wait_s  = 8'd0;
          state_s = S_RD;
        end else begin
          state_s = S_REQ;
        end
      end
      S_RD: begin
        if (rd_done_s) state_s = S_CAP;
        else           wait_s  = wait_r + 8'd1;
      end
      S_CAP: begin
        data_s  = bm_rdata;
        state_s = S_WR;
      end
      S_WR: begin
        src_s = src_r + 16'd1;
        dst_s = dst_r + 16'd1;
        len_s = len_r - 16'd1;
        if (len_r == 16'd1) begin
          state_s = S_FIN;
        end else if (abort_s) begin
          aborted_s = 1'b1;
          state_s   = S_FIN;
        end else begin
          wait_s  = 8'd0;
          state_s = S_RD;
        end
      end
      S_FIN: begin
        done_s       = 1'b1;
        abort_pend_s = 1'b0;
        state_s      = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they leave a flop.
    bus_req_s = (state_s inside {S_REQ, S_RD, S_CAP, S_WR});
    bm_we_s   = (state_s == S_WR);
    if (state_s == S_RD)      bm_addr_s = src_s;
    else if (state_s == S_WR) bm_addr_s = dst_s;
    else                      bm_addr_s = bm_addr_r;
    if (state_s == S_WR) bm_wdata_s = data_s;
    else                 bm_wdata_s = bm_wdata_r;
    irq_s = done_s & ie_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      src_r        <= 16'd0;
      dst_r        <= 16'd0;
      len_r        <= 16'd0;
      data_r       <= 8'd0;
      wait_r       <= 8'd0;
      ie_r         <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
      dout_r       <= 8'd0;
      bus_req_r    <= 1'b0;
      bm_we_r      <= 1'b0;
      bm_addr_r    <= 16'd0;
      bm_wdata_r   <= 8'd0;
      irq_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      src_r        <= src_s;
      dst_r        <= dst_s;
      len_r        <= len_s;
      data_r       <= data_s;
      wait_r       <= wait_s;
      ie_r         <= ie_s;
      done_r       <= done_s;
      aborted_r    <= aborted_s;
      abort_pend_r <= abort_pend_s;
      dout_r       <= dout_s;
      bus_req_r    <= bus_req_s;
      bm_we_r      <= bm_we_s;
      bm_addr_r    <= bm_addr_s;
      bm_wdata_r   <= bm_wdata_s;
      irq_r        <= irq_s;
    end
  end

  assign dout     = dout_r;
  assign bus_req  = bus_req_r;
  assign bm_addr  = bm_addr_r;
  assign bm_we    = bm_we_r;
  assign bm_wdata = bm_wdata_r;
  assign irq      = irq_r;

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory byte-copy engine for the 65C02 SoC; the bus *initiator* counterpart to the existing slot responders (VIA, ACIA).
- CPU programs it through an MMIO controller slot using the same rs/we/en/din/dout slot interface as the VIA and ACIA.
- When started, it requests the system bus (top level holds the CPU via RDY and returns a grant). It then issues read and write cycles on the shared RAM/ROM/MMIO bus until the copy completes.

Parameters:
- RD_LAT, 1, bus read latency in cycles (synchronous ROM/RAM: data valid the cycle after the address is driven).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rs  in  3  slot register select
- we  in  1  slot write enable
- en  in  1  slot chip select
- din  in  8  slot write data
- dout  out  8  slot read data
- bus_req  out  1  request for the system bus (top level deasserts CPU RDY)
- bus_gnt  in  1  bus granted (CPU halted); never revoked while bus_req is high
- bm_addr  out  16  initiator address
- bm_we  out  1  initiator write enable, active-high
- bm_wdata  out  8  initiator write data
- bm_rdata  in  8  bus read data (DI mux output), valid RD_LAT cycles after the address
- irq  out  1  completion interrupt, level

Behaviour:
- Registers (rs):
  - 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI.
  - 6 CTRL: write-only. bit0 START, bit1 ABORT, bit2 IE; reads return {5'b0, IE, 2'b0}.
  - 7 STATUS: read-only. bit0 BUSY, bit1 DONE, bit2 ABORTED.
- Slot write: occurs when en & we at a clk edge.
- Slot read:
  - dout is registered; it updates on the edge where en & ~we, returning the selected register.
  - dout holds its value otherwise.
  - SRC/DST/LEN read back their live values (they advance during a copy).
- Reset values:
  - All registers 0; IE=0; DONE=0; ABORTED=0.
  - State IDLE; bus_req=0; bm_we=0; bm_addr=0; bm_wdata=0; dout=0; irq=0.
  - Reset mid-transfer aborts immediately: no further bus cycle is issued and bm_we is 0 the cycle after rst.
- While BUSY:
  - Writes to rs 0-5 are ignored.
  - A CTRL write with START=1 is ignored; IE still updates.
- FSM states: IDLE, REQ, RD, CAP, WR, FIN.
  - IDLE: on a CTRL write with START=1, clear DONE and ABORTED.
    - LEN==0 -> FIN directly (no bus cycles, bus_req never asserted).
    - Otherwise -> REQ.
  - REQ: bus_req=1; stay until bus_gnt=1, then -> RD.
  - RD: bm_addr=SRC, bm_we=0. Advance to CAP (after RD_LAT-1 extra wait cycles when RD_LAT>1).
  - CAP: latch bm_rdata into the data register -> WR.
  - WR:
    - bm_addr=DST, bm_we=1, bm_wdata=latched byte.
    - On exit: SRC+=1, DST+=1, LEN-=1, each 16-bit wrap-around (FFFF -> 0000).
    - If new LEN==0 -> FIN, else -> RD.
  - FIN: bus_req=0, DONE=1; -> IDLE next cycle.
- Bus signals:
  - bus_req is high from entry to REQ through the last WR cycle inclusive.
  - bm_we is high only in WR.
- Throughput: 3 cycles per byte (RD_LAT=1), plus grant latency.
- ABORT:
  - A CTRL write with ABORT=1 while busy takes effect at the next RD or REQ boundary. An in-flight RD/CAP/WR sequence completes, so no partial byte is left.
  - Then -> FIN with ABORTED=1 and DONE=1; registers keep their current values.
  - ABORT in IDLE has no effect.
  - START and ABORT in the same write: START wins when idle; when busy, both apply as described above.
- BUSY = (state != IDLE) || (state == FIN).
- irq = DONE & IE.
  - DONE is cleared by reading STATUS (the edge after the read) or by a new START.
  - Clearing IE drops irq without clearing DONE.
- Overlapping regions are copied ascending, byte by byte; no overlap correction.
- SRC or DST may target any address, including MMIO; the engine does not decode addresses.

Test Plan:
- Basic copy: RAM 0x0200..0x0203 = 11,22,33,44; program SRC=0x0200, DST=0x0300, LEN=4, START with bus_gnt tied to bus_req delayed 1 cycle -> 0x0300..0x0303 = 11,22,33,44; exactly 4 cycles with bm_we=1; STATUS reads 0x02; final SRC=0x0204, LEN=0.
- Zero length: LEN=0, START -> bus_req never asserted; DONE=1 within 2 cycles; with IE=1, irq=1 until STATUS is read, then 0.
- Grant delay: hold bus_gnt=0 for 10 cycles after bus_req -> no bm_we pulses and bm_addr unused until the grant; copy then completes correctly.
- Wrap-around: SRC=0xFFFF (ROM byte 0xA5), DST=0x00FF, LEN=2 -> reads 0xFFFF then 0x0000; writes 0x00FF then 0x0100; final SRC=0x0001, DST=0x0101.
- Abort: LEN=100, write CTRL=0x02 after the 5th WR -> at most 6 bytes written; STATUS=0x06; LEN reads 94 or 95 consistent with the bytes written; a subsequent START runs normally.
- Reset mid-copy: assert rst during a WR cycle -> the next cycle has bm_we=0 and bus_req=0; all registers read 0; STATUS=0x00.
